// File: rtl/oa_pkg.sv
// Shared types for the online adder-tree sequencer.
// State encoding and signed-digit helpers.
package oa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // {p,n} signed-digit encoding; (1,1) also reads as zero
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    function automatic logic sd_is_neg(input logic p, input logic n);
        return {p, n} == SD_NEG;
    endfunction

    function automatic logic sd_is_pos(input logic p, input logic n);
        return {p, n} == SD_POS;
    endfunction

endpackage

// File: rtl/oa_out_stage.sv
// Registered result digit stage with first-nonzero
// negative detector for early ReLU termination.
module oa_out_stage
    import oa_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             neg_clr,
    input  logic             relu_q,
    input  logic             cap,
    input  logic [CNT_W-1:0] cap_idx,
    input  logic             z_p,
    input  logic             z_n,
    output logic             term,
    output logic             out_p,
    output logic             out_n,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_idx,
    output logic             neg_detect
);

    logic first_nz;
    logic chk;
    logic emit;

    assign chk  = cap & relu_q & ~first_nz;
    assign term = chk & sd_is_neg(z_p, z_n);
    assign emit = cap & ~term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_nz <= 1'b0;
        end else if (clr) begin
            first_nz <= 1'b0;
        end else if (chk && sd_is_pos(z_p, z_n)) begin
            first_nz <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_p     <= 1'b0;
            out_n     <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            out_p     <= emit & z_p;
            out_n     <= emit & z_n;
            out_valid <= emit;
            out_idx   <= emit ? cap_idx : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_detect <= 1'b0;
        end else if (neg_clr) begin
            neg_detect <= 1'b0;
        end else if (term) begin
            neg_detect <= 1'b1;
        end
    end

endmodule

// File: rtl/oa_tree_seq_ctrl.sv
// Sequencer for one MSD-first online adder-tree evaluation:
// clear, feed digits, drain the online delay, capture results.
module oa_tree_seq_ctrl
    import oa_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int TREE_DELAY = 10,
    parameter int CNT_W      = $clog2(N_DIGITS + TREE_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             relu_en,
    input  logic             z_p,
    input  logic             z_n,
    output logic             tree_clr,
    output logic             dig_en,
    output logic             dig_zero,
    output logic [CNT_W-1:0] dig_idx,
    output logic             out_p,
    output logic             out_n,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             neg_detect
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_DIGITS + TREE_DELAY - 1);
    localparam logic [CNT_W-1:0] ND_C  = CNT_W'(N_DIGITS);
    localparam logic [CNT_W-1:0] TD_C  = CNT_W'(TREE_DELAY);
    localparam logic [CNT_W-1:0] MSB_I = CNT_W'(N_DIGITS - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cyc;
    logic             relu_q;
    logic             accept;
    logic             in_run;
    logic             cap;
    logic             term;

    assign in_run = state == RUN;
    assign accept = start & ~abort & (state == IDLE || state == DONE);
    assign cap    = in_run & (cyc >= TD_C) & ~abort;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = CLEAR;
            CLEAR: state_nx = RUN;
            RUN:   if (term || cyc == LAST) state_nx = DONE;
            DONE:  state_nx = accept ? CLEAR : IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cyc    <= '0;
            relu_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) relu_q <= relu_en;
            // cyc saturates at LAST; it never wraps
            if (state == CLEAR) begin
                cyc <= '0;
            end else if (in_run && cyc != LAST) begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    assign tree_clr = state == CLEAR;
    assign dig_en   = in_run & (cyc < ND_C);
    assign dig_zero = in_run & (cyc >= ND_C);
    assign dig_idx  = dig_en ? cyc : (dig_zero ? MSB_I : '0);
    assign busy     = state != IDLE;
    assign done     = state == DONE;

    oa_out_stage #(
        .CNT_W (CNT_W)
    ) u_out (
        .clk        (clk),
        .rst        (rst),
        .clr        (tree_clr),
        .neg_clr    (accept),
        .relu_q     (relu_q),
        .cap        (cap),
        .cap_idx    (cyc - TD_C),
        .z_p        (z_p),
        .z_n        (z_n),
        .term       (term),
        .out_p      (out_p),
        .out_n      (out_n),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .neg_detect (neg_detect)
    );

endmodule

// File: tb/tb_oa_tree_seq_ctrl.sv
// Directed bench for oa_tree_seq_ctrl with a delay-line
// tree model and per-cycle output monitor.
module tb_oa_tree_seq_ctrl;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          relu_en = 1'b0;
    logic          z_p = 1'b0;
    logic          z_n = 1'b0;
    logic          tree_clr, dig_en, dig_zero;
    logic [CW-1:0] dig_idx;
    logic          out_p, out_n, out_valid;
    logic [CW-1:0] out_idx;
    logic          busy, done, neg_detect;

    oa_tree_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .relu_en    (relu_en),
        .z_p        (z_p),
        .z_n        (z_n),
        .tree_clr   (tree_clr),
        .dig_en     (dig_en),
        .dig_zero   (dig_zero),
        .dig_idx    (dig_idx),
        .out_p      (out_p),
        .out_n      (out_n),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done),
        .neg_detect (neg_detect)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int pat [8];
    int obs [32];
    int ncyc = 0, tcnt = 63;
    int busy_cnt, clr_cnt, den_cnt, dz_cnt, idx_bad;
    int ov_cnt, oidx_bad, first_den, first_ov;
    int done_cnt, last_done, done_gap, idle_gap;

    task automatic clear_stats();
        busy_cnt = 0; clr_cnt = 0; den_cnt = 0; dz_cnt = 0;
        idx_bad = 0; ov_cnt = 0; oidx_bad = 0;
        first_den = -1; first_ov = -1;
        done_cnt = 0; last_done = -1; done_gap = -1; idle_gap = 0;
        for (int i = 0; i < 32; i++) obs[i] = 99;
    endtask

    // Monitor plus tree model: result digit k appears when cyc == 10+k
    always @(negedge clk) begin
        int v, dv;
        ncyc++;
        if (busy) busy_cnt++;
        if (tree_clr) clr_cnt++;
        if (dig_en) begin
            if (dig_idx == 0) first_den = ncyc;
            if (int'(dig_idx) != den_cnt) idx_bad++;
            den_cnt++;
        end
        if (dig_zero) dz_cnt++;
        if (out_valid) begin
            dv = (out_p && !out_n) ? 1 : ((out_n && !out_p) ? -1 : 0);
            if (ov_cnt == 0) first_ov = ncyc;
            if (int'(out_idx) != ov_cnt) oidx_bad++;
            obs[out_idx] = dv;
            ov_cnt++;
        end
        if (done) begin
            if (done_cnt > 0) done_gap = ncyc - last_done;
            last_done = ncyc;
            done_cnt++;
        end
        if (done_cnt > 0 && !busy) idle_gap++;
        if (dig_en && dig_idx == 0) tcnt = 0;
        else if (tcnt < 63) tcnt++;
        v = (tcnt >= 10 && tcnt < 18) ? pat[tcnt-10] : 0;
        z_p = (v == 1);
        z_n = (v == -1);
    end

    task automatic set_pat(input int a0, a1, a2, a3, a4, a5, a6, a7);
        pat[0] = a0; pat[1] = a1; pat[2] = a2; pat[3] = a3;
        pat[4] = a4; pat[5] = a5; pat[6] = a6; pat[7] = a7;
    endtask

    task automatic pulse_start(input logic relu);
        @(posedge clk); #1;
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int n, input string tag);
        int k;
        k = 0;
        while (done_cnt < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt < n) check({tag, "_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int k;
        set_pat(1, 0, -1, 1, 0, 0, -1, 1);
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_outs", {tree_clr, dig_en, dig_zero, out_valid, done, neg_detect}, 0);
        rst = 1'b1;

        // Full run, relu off
        clear_stats();
        pulse_start(1'b0);
        wait_done(1, "full");
        check("full_den", den_cnt, 8);
        check("full_idx", idx_bad, 0);
        check("full_dz", dz_cnt, 10);
        check("full_ov", ov_cnt, 8);
        check("full_lat", first_ov - first_den, 11);
        check("full_oidx", oidx_bad, 0);
        for (int i = 0; i < 8; i++) check($sformatf("full_dig%0d", i), obs[i], pat[i]);
        check("full_done", done_cnt, 1);
        check("full_neg", neg_detect, 0);
        check("full_clr", clr_cnt, 1);
        check("full_busy", busy_cnt, 20);

        // Asynchronous reset while digits stream out
        clear_stats();
        pulse_start(1'b0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reach", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_outs", {busy, tree_clr, dig_en, dig_zero, out_valid, out_p, out_n, done}, 0);
        check("rst_mid_idx", int'(dig_idx) + int'(out_idx), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_idle", busy, 0);
        clear_stats();
        pulse_start(1'b0);
        wait_done(1, "rst_run");
        check("rst_clr1", clr_cnt, 1);

        // Negative lead with relu: two zeros, then -1
        set_pat(0, 0, -1, 1, 1, 1, 1, 1);
        clear_stats();
        pulse_start(1'b1);
        wait_done(1, "neg");
        check("neg_ov", ov_cnt, 2);
        check("neg_lastidx", obs[2], 99);
        check("neg_flag", neg_detect, 1);
        check("neg_done_t", last_done - first_den, 13);
        check("neg_busy", busy_cnt, 15);
        check("neg_dcnt", done_cnt, 1);
        repeat (2) @(posedge clk);
        #1;
        check("neg_hold", neg_detect, 1);

        // Positive lead with relu: later -1 digits pass through
        set_pat(1, -1, -1, 0, -1, 0, 0, -1);
        clear_stats();
        pulse_start(1'b1);
        check("pos_negclr", neg_detect, 0);
        wait_done(1, "pos");
        check("pos_ov", ov_cnt, 8);
        check("pos_neg", neg_detect, 0);
        check("pos_dig1", obs[1], -1);
        check("pos_dig7", obs[7], -1);

        // Back-to-back with start held high
        set_pat(1, 0, -1, 1, 0, 0, -1, 1);
        clear_stats();
        @(posedge clk); #1;
        relu_en = 1'b0;
        start   = 1'b1;
        k = 0;
        while (done_cnt < 3 && k < 120) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("b2b_cnt", done_cnt, 3);
        check("b2b_gap", done_gap, 20);
        check("b2b_idle", idle_gap, 0);
        start = 1'b0;
        repeat (25) @(posedge clk);

        // Abort at cyc 5 together with start
        clear_stats();
        pulse_start(1'b0);
        k = 0;
        while (!(dig_en && dig_idx == 5) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("abt_reach", int'(dig_idx), 5);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abt_idle", busy, 0);
        repeat (30) @(posedge clk);
        check("abt_done", done_cnt, 0);
        check("abt_ov", ov_cnt, 0);

        // Start pulses during RUN are ignored
        clear_stats();
        pulse_start(1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, "ign");
        repeat (20) @(posedge clk);
        check("ign_done", done_cnt, 1);
        check("ign_busy", busy_cnt, 20);
        check("ign_den", den_cnt, 8);
        check("ign_ov", ov_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/oa_tree_seq_ctrl.md
Name: oa_tree_seq_ctrl

Overview:
- Sequencer for one digit-serial, MSD-first online adder-tree evaluation, e.g. a 25-input OA tree built from OA_Tree_16, OA_Tree_9 and an OA stage.
- Per start: clears the tree, steps the operand-digit index, inserts zero digits while the tree's online delay drains, and captures result digits into a registered output stage.
- With relu_en, detects a negative result from its first nonzero digit and terminates early.

Parameters:
- N_DIGITS, 8, operand/result digits per evaluation.
- TREE_DELAY, 10, online delay of the attached tree in cycles (first result digit appears on z when cyc equals TREE_DELAY).
- CNT_W, $clog2(N_DIGITS+TREE_DELAY+1), cycle counter width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request one evaluation; sampled in IDLE and DONE only.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- relu_en  in  1  enable early negative termination; sampled at start.
- z_p, z_n  in  1 each  tree result digit. Encoding: (1,0) is +1, (0,1) is -1, (0,0) and (1,1) are 0.
- tree_clr  out  1  synchronous clear to the tree datapath.
- dig_en  out  1  operand digit valid; the operand mux presents digit dig_idx.
- dig_zero  out  1  operand mux drives (0,0) on all tree inputs.
- dig_idx  out  CNT_W  operand digit index, 0 = MSD.
- out_p, out_n  out  1 each  registered result digit.
- out_valid  out  1  out_p/out_n hold a result digit this cycle.
- out_idx  out  CNT_W  index of the emitted result digit, 0 = MSD.
- busy  out  1  high in CLEAR, RUN, DONE.
- done  out  1  one-cycle pulse in DONE.
- neg_detect  out  1  evaluation ended by negative detection; held until next start.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, cyc 0, first_nz 0. All outputs 0, including neg_detect.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: start moves to CLEAR. Latches relu_en into relu_q. Clears neg_detect.
- CLEAR (1 cycle):
  - tree_clr=1, cyc is loaded to 0, first_nz is cleared.
  - Next state is RUN.
- RUN: cyc counts 0 to N_DIGITS+TREE_DELAY-1.
  - When cyc < N_DIGITS: dig_en=1, dig_idx=cyc, dig_zero=0.
  - Otherwise: dig_en=0, dig_zero=1, dig_idx holds N_DIGITS-1.
- Capture, when cyc >= TREE_DELAY:
  - z is sampled at the edge.
  - In the next cycle: out_p/out_n = the sampled z, out_valid=1, out_idx = cyc-TREE_DELAY.
  - Output latency is TREE_DELAY+1 cycles after the first dig_en cycle. Exactly N_DIGITS out_valid cycles per full run.
- Early termination (relu_q=1, first_nz=0, capture cycle):
  - If z is +1: set first_nz and continue.
  - If z is 0: continue.
  - If z is -1: that digit is not emitted (out_valid=0 next cycle), neg_detect<=1, go to DONE.
  - Digits after first_nz=1 are never checked.
- The last RUN cycle (cyc = N_DIGITS+TREE_DELAY-1) goes to DONE. The final out_valid occurs in the DONE cycle.
- DONE (1 cycle): done=1.
  - start in DONE goes directly to CLEAR (back-to-back runs, no IDLE bubble). Otherwise go to IDLE.
  - neg_detect stays valid through DONE and IDLE.
- abort in any state: next state IDLE, all strobes 0, no done pulse. abort wins over start in the same cycle.
- start in CLEAR or RUN is ignored.
- When relu_q=0 and z is negative: the digit is emitted normally and neg_detect stays 0.
- Counters never wrap. cyc saturates at its terminal value.

Decomposition:
- Shared package oa_pkg: state enum (IDLE, CLEAR, RUN, DONE), SD digit encoding constants (SD_POS, SD_NEG, SD_ZERO), and function sd_is_neg(p, n).
- One sub-module, oa_out_stage: registered result digit, out_valid, out_idx and the first-nonzero/negative detector, driven by a capture strobe from the FSM.

Test Plan:
- Reset and basic timing:
  - Stimulus: rst low mid-RUN.
  - Required response: all outputs 0 immediately (asynchronous). After release, FSM in IDLE; start gives tree_clr for exactly 1 cycle.
- Full run, relu_en=0, N_DIGITS=8, TREE_DELAY=10, z pattern +1,0,-1,+1,0,0,-1,+1:
  - dig_en high 8 cycles with dig_idx 0..7, then dig_zero high 10 cycles.
  - out_valid high 8 cycles, starting 11 cycles after the first dig_en, out_idx 0..7 with the pattern reproduced.
  - done pulses once; neg_detect stays 0.
- Negative detection, relu_en=1, z pattern 0,0,-1,...:
  - out_valid is high for out_idx 0 and 1 only, the -1 digit is suppressed.
  - neg_detect=1 and done pulses 1 cycle after the -1 sample.
  - Total busy cycles = 1+13+1.
- Positive lead, relu_en=1, z pattern +1,-1,-1,...:
  - No early termination; 8 digits emitted; neg_detect=0.
- Back-to-back runs:
  - Stimulus: start held high continuously.
  - Required response: DONE goes directly to CLEAR with no IDLE cycle; done pulses exactly 20 cycles apart.
- Abort and ignored start:
  - Stimulus: abort at cyc=5 of RUN, together with start.
  - Required response: IDLE next cycle, no done pulse, no further out_valid.
  - Separately: start pulses during RUN do not extend or restart the run.
